// File: rtl/gen_seq_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gen_seq_tx : serial MSB-first pattern transmitter with repeat and idle gap |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gen_seq_tx #(
  parameter int SEQ_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [SEQ_W-1:0] seq,
  input  logic [CNT_W-1:0] rep,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SEQ_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx,   w_idx_nxt;
  logic [CNT_W-1:0] r_rem,   w_rem_nxt;
  logic [GAP_W-1:0] r_gcnt,  w_gcnt_nxt;
  logic [SEQ_W-1:0] r_seq,   w_seq_nxt;
  logic [GAP_W-1:0] r_gap,   w_gap_nxt;

  logic w_out_nxt, w_valid_nxt, w_sof_nxt, w_busy_nxt, w_done_nxt;
  logic w_accept;

  // Outputs lag the state by one cycle, so the visible done cycle already
  // sees IDLE; the registered done flag keeps that cycle from accepting.
  assign w_accept = (r_state == S_IDLE) && start && !abort && !done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
      r_gcnt  <= '0;
      r_seq   <= '0;
      r_gap   <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      sof     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rem   <= w_rem_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_seq   <= w_seq_nxt;
      r_gap   <= w_gap_nxt;
      out     <= w_out_nxt;
      valid   <= w_valid_nxt;
      sof     <= w_sof_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
    w_gcnt_nxt  = r_gcnt;
    w_seq_nxt   = r_seq;
    w_gap_nxt   = r_gap;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_seq_nxt = seq;
            w_gap_nxt = gap;
            w_rem_nxt = rep;
            if (rep != '0) begin
              w_state_nxt = S_SEND;
              w_idx_nxt   = IDX_MAX;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_SEND: begin
          if (r_idx != '0) begin
            w_idx_nxt = r_idx - IDX_W'(1);
          end else begin
            if (r_rem != '0) w_rem_nxt = r_rem - CNT_W'(1);
            if (r_rem <= CNT_W'(1)) begin
              w_state_nxt = S_DONE;
            end else if (r_gap != '0) begin
              w_state_nxt = S_GAP;
              w_gcnt_nxt  = r_gap;
            end else begin
              w_idx_nxt = IDX_MAX;
            end
          end
        end
        S_GAP: begin
          if (r_gcnt != '0) w_gcnt_nxt = r_gcnt - GAP_W'(1);
          if (r_gcnt <= GAP_W'(1)) begin
            w_state_nxt = S_SEND;
            w_idx_nxt   = IDX_MAX;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // An abort clears every output on the same edge that returns to IDLE.
  always_comb begin
    w_out_nxt   = 1'b0;
    w_valid_nxt = 1'b0;
    w_sof_nxt   = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    if (!abort) begin
      case (r_state)
        S_SEND: begin
          w_out_nxt   = r_seq[r_idx];
          w_valid_nxt = 1'b1;
          w_sof_nxt   = (r_idx == IDX_MAX);
          w_busy_nxt  = 1'b1;
        end
        S_GAP: begin
          w_busy_nxt = 1'b1;
        end
        S_DONE: begin
          w_busy_nxt = 1'b1;
          w_done_nxt = 1'b1;
        end
        default: begin
          w_busy_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gen_seq_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_gen_seq_tx : self-checking bench for gen_seq_tx                         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_gen_seq_tx;

  localparam int SEQ_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [SEQ_W-1:0] seq = '0;
  logic [CNT_W-1:0] rep = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             out, valid, sof, busy, done;
  logic [4:0]       obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];

  gen_seq_tx #(.SEQ_W(SEQ_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .seq   (seq),
    .rep   (rep),
    .gap   (gap),
    .out   (out),
    .valid (valid),
    .sof   (sof),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Observed vector layout: {valid, out, sof, busy, done}
  assign obs = {valid, out, sof, busy, done};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected visible trace from the acceptance edge onward: one quiet cycle,
  // the bits/gaps of every repetition, the done cycle, then idle again.
  task automatic build_model(input logic [SEQ_W-1:0] s, input int r, input int g);
    exp_q.delete();
    exp_q.push_back(5'b00000);
    for (int k = 0; k < r; k++) begin
      for (int b = 0; b < SEQ_W; b++)
        exp_q.push_back({1'b1, s[SEQ_W-1-b], (b == 0), 1'b1, 1'b0});
      if (k < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00011);
    exp_q.push_back(5'b00000);
  endtask

  task automatic capture(input int n, input bit scramble, input bit hold);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      step();
      if (!hold) start = 1'b0;
      obs_q.push_back(obs);
      if (scramble) begin
        seq = SEQ_W'($urandom_range(0, 15));
        rep = CNT_W'($urandom_range(0, 255));
        gap = GAP_W'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic launch(input logic [SEQ_W-1:0] s, input int r, input int g);
    seq   = s;
    rep   = CNT_W'(r);
    gap   = GAP_W'(g);
    start = 1'b1;
    build_model(s, r, g);
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b required %b", obs, 5'b00000);
    end
    start = 1'b1;
    rep   = 8'd1;
    step();
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_start_ignored: got %b required %b", obs, 5'b00000);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %b required %b", obs, 5'b00000);
    end
  endtask

  task automatic test_single();
    launch(4'b0101, 1, 0);
    capture(exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(4'b0101, 3, 0);
    capture(exp_q.size(), 1, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gap();
    launch(4'b1101, 2, 2);
    capture(exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL gap cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rep_zero();
    launch(4'b1111, 0, 3);
    capture(exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rep_zero cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_held();
    launch(4'b1001, 2, 1);
    capture(exp_q.size(), 1, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL start_held_a cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    launch(4'b0110, 1, 0);
    capture(exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL start_held_b cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    int g;
    int stop_at;
    g = $urandom_range(0, 2);
    launch(SEQ_W'($urandom_range(0, 15)), 3, g);
    stop_at = 1 + (SEQ_W + g) + 2;
    for (int i = 0; i <= stop_at; i++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL abort_prefix cycle %0d: got %b required %b", i, obs, exp_q[i]);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== 5'b00000) begin
        n_fail++;
        $display("FAIL abort_idle cycle %0d: got %b required %b", i, obs, 5'b00000);
      end
      step();
    end
    seq   = 4'b1111;
    rep   = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    step();
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL abort_blocks_start: got %b required %b", obs, 5'b00000);
    end
  endtask

  task automatic test_reset_mid_gap();
    launch(4'b1011, 2, 3);
    for (int i = 0; i < 1 + SEQ_W + 2; i++) begin
      step();
      start = 1'b0;
    end
    n_checks++;
    if (obs !== 5'b00010) begin
      n_fail++;
      $display("FAIL mid_gap_state: got %b required %b", obs, 5'b00010);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_reset: got %b required %b", obs, 5'b00000);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    step();
    n_checks++;
    if (obs !== 5'b00000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required %b", obs, 5'b00000);
    end
    launch(4'b0011, 2, 1);
    capture(exp_q.size(), 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL post_reset_xfer cycle %0d: got %b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      launch(SEQ_W'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 3));
      capture(exp_q.size(), 1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random t%0d cycle %0d: got %b required %b", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_rep_zero();
    test_start_held();
    test_abort();
    test_reset_mid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
